// File: rtl/translation_pkg.sv
// rtl/translation_pkg.sv - shared exception codes, size encoding and request/response types
package translation_pkg;

  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic [1:0] {
    MSIZE_BYTE = 2'd0,
    MSIZE_HALF = 2'd1,
    MSIZE_WORD = 2'd2
  } msize_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } dstate_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] paddr;
    logic        store;
    logic [3:0]  strobe;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic        uncached;
  } dreq_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
  } dresp_t;

  // The illegal size code 3 travels on the bus as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd3) ? MSIZE_WORD : size;
  endfunction

endpackage

// File: rtl/dreq_align.sv
// rtl/dreq_align.sv - byte-lane strobe, store replication, misalignment and load extension
module dreq_align
  import translation_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_strobe,
  output logic [31:0] o_wdata,
  output logic        o_misalign,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shift;

  assign w_shift = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_strobe   = 4'hF;
    o_wdata    = i_wdata;
    o_misalign = |i_addr_lo;
    o_rdata    = w_shift;
    case (i_size)
      MSIZE_BYTE: begin
        o_strobe   = 4'b0001 << i_addr_lo;
        o_wdata    = {4{i_wdata[7:0]}};
        o_misalign = 1'b0;
        o_rdata    = {{24{i_signed & w_shift[7]}}, w_shift[7:0]};
      end
      MSIZE_HALF: begin
        o_strobe   = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata    = {2{i_wdata[15:0]}};
        o_misalign = i_addr_lo[0];
        o_rdata    = {{16{i_signed & w_shift[15]}}, w_shift[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dreq_issue.sv
// rtl/dreq_issue.sv - data-side request issuer between translation and the D-cache/uncached bus
module dreq_issue
  import translation_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_vaddr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              flush,
  input  logic [ADDR_W-1:0] tr_paddr,
  input  logic              tr_uncached,
  input  logic              tr_refill,
  input  logic              tr_invalid,
  input  logic              tr_modified,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_paddr,
  output logic              dreq_store,
  output logic [3:0]        dreq_strobe,
  output logic [1:0]        dreq_size,
  output logic [DATA_W-1:0] dreq_wdata,
  output logic              dreq_uncached,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [DATA_W-1:0] dresp_rdata,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              exc_valid,
  output logic [4:0]        exc_code,
  output logic              exc_refill,
  output logic [ADDR_W-1:0] badvaddr
);

  dstate_t           r_state;
  dstate_t           w_next;
  logic              r_killed;
  logic              r_cpl;
  logic [ADDR_W-1:0] r_paddr;
  logic [1:0]        r_size;
  logic              r_store;
  logic              r_signed;
  logic              r_uncached;
  logic [3:0]        r_strobe;
  logic [DATA_W-1:0] r_wdata;
  logic              r_done;
  logic [DATA_W-1:0] r_rdata;
  logic              r_exc_valid;
  logic [4:0]        r_exc_code;
  logic              r_exc_refill;
  logic [ADDR_W-1:0] r_badvaddr;

  logic              w_accept;
  logic              w_issue;
  logic              w_exc;
  logic              w_exc_refill;
  logic [4:0]        w_exc_code;
  logic              w_complete;
  logic              w_kill;
  logic              w_req_misalign;
  logic [3:0]        w_req_strobe;
  logic [31:0]       w_req_wdata;
  logic [31:0]       w_load_data;
  logic [31:0]       w_unused_req_rdata;
  logic [3:0]        w_unused_rsp_strobe;
  logic [31:0]       w_unused_rsp_wdata;
  logic              w_unused_rsp_misalign;
  dreq_t             w_dreq;
  dresp_t            w_dresp;

  assign w_dresp.addr_ok = dresp_addr_ok;
  assign w_dresp.data_ok = dresp_data_ok;
  assign w_dresp.rdata   = dresp_rdata;

  dreq_align u_req_align (
    .i_addr_lo  (req_vaddr[1:0]),
    .i_size     (req_size),
    .i_signed   (req_signed),
    .i_wdata    (req_wdata),
    .i_rdata    (32'h0),
    .o_strobe   (w_req_strobe),
    .o_wdata    (w_req_wdata),
    .o_misalign (w_req_misalign),
    .o_rdata    (w_unused_req_rdata)
  );

  dreq_align u_rsp_align (
    .i_addr_lo  (r_paddr[1:0]),
    .i_size     (r_size),
    .i_signed   (r_signed),
    .i_wdata    (32'h0),
    .i_rdata    (w_dresp.rdata),
    .o_strobe   (w_unused_rsp_strobe),
    .o_wdata    (w_unused_rsp_wdata),
    .o_misalign (w_unused_rsp_misalign),
    .o_rdata    (w_load_data)
  );

  always_comb begin
    w_exc        = 1'b1;
    w_exc_refill = 1'b0;
    w_exc_code   = '0;
    if (w_req_misalign) begin
      w_exc_code = req_store ? EXC_ADES : EXC_ADEL;
    end else if (tr_refill) begin
      w_exc_code   = req_store ? EXC_TLBS : EXC_TLBL;
      w_exc_refill = 1'b1;
    end else if (tr_invalid) begin
      w_exc_code = req_store ? EXC_TLBS : EXC_TLBL;
    end else if (tr_modified && req_store) begin
      w_exc_code = EXC_MOD;
    end else begin
      w_exc = 1'b0;
    end
  end

  // r_cpl marks the cycle right after completion, which never takes a new request.
  assign w_accept   = (r_state == ST_IDLE) & req_valid & ~flush & ~r_cpl;
  assign w_issue    = w_accept & ~w_exc;
  assign w_complete = w_dresp.data_ok &
                      (((r_state == ST_ADDR) & w_dresp.addr_ok) | (r_state == ST_DATA));
  assign w_kill     = r_killed | flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_issue) w_next = ST_ADDR;
      ST_ADDR: if (w_dresp.addr_ok) w_next = w_dresp.data_ok ? ST_IDLE : ST_DATA;
      ST_DATA: if (w_dresp.data_ok) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_dreq.valid    = (r_state == ST_ADDR);
    w_dreq.paddr    = {r_paddr[ADDR_W-1:2], 2'b00};
    w_dreq.store    = r_store;
    w_dreq.strobe   = r_strobe;
    w_dreq.size     = r_size;
    w_dreq.wdata    = r_wdata;
    w_dreq.uncached = r_uncached;
    stall           = (r_state != ST_IDLE) | w_issue;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_paddr    <= '0;
      r_size     <= '0;
      r_store    <= 1'b0;
      r_signed   <= 1'b0;
      r_uncached <= 1'b0;
      r_strobe   <= '0;
      r_wdata    <= '0;
    end else if (w_issue) begin
      r_paddr    <= tr_paddr;
      r_size     <= norm_size(req_size);
      r_store    <= req_store;
      r_signed   <= req_signed;
      r_uncached <= tr_uncached;
      r_strobe   <= w_req_strobe;
      r_wdata    <= w_req_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_exc_valid  <= 1'b0;
      r_exc_code   <= '0;
      r_exc_refill <= 1'b0;
      r_badvaddr   <= '0;
    end else begin
      r_exc_valid <= w_accept & w_exc;
      if (w_accept & w_exc) begin
        r_exc_code   <= w_exc_code;
        r_exc_refill <= w_exc_refill;
        r_badvaddr   <= req_vaddr;
      end
    end
  end

  // A killed transaction still finishes its handshake; only its result is dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_killed <= 1'b0;
      r_cpl    <= 1'b0;
      r_done   <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_cpl  <= w_complete;
      r_done <= w_complete & ~w_kill;
      if (w_complete & ~w_kill & ~r_store) r_rdata <= w_load_data;
      if (w_complete)                             r_killed <= 1'b0;
      else if (flush && (r_state != ST_IDLE))     r_killed <= 1'b1;
    end
  end

  assign dreq_valid    = w_dreq.valid;
  assign dreq_paddr    = w_dreq.paddr;
  assign dreq_store    = w_dreq.store;
  assign dreq_strobe   = w_dreq.strobe;
  assign dreq_size     = w_dreq.size;
  assign dreq_wdata    = w_dreq.wdata;
  assign dreq_uncached = w_dreq.uncached;
  assign done          = r_done;
  assign rdata         = r_rdata;
  assign exc_valid     = r_exc_valid;
  assign exc_code      = r_exc_code;
  assign exc_refill    = r_exc_refill;
  assign badvaddr      = r_badvaddr;

endmodule

// File: tb/tb_dreq_issue.sv
// tb/tb_dreq_issue.sv - randomized self-checking bench for dreq_issue against a transaction-level model
module tb_dreq_issue;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_vaddr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] tr_paddr = 32'h0;
  logic        tr_uncached = 1'b0;
  logic        tr_refill = 1'b0;
  logic        tr_invalid = 1'b0;
  logic        tr_modified = 1'b0;
  logic        dreq_valid;
  logic [31:0] dreq_paddr;
  logic        dreq_store;
  logic [3:0]  dreq_strobe;
  logic [1:0]  dreq_size;
  logic [31:0] dreq_wdata;
  logic        dreq_uncached;
  logic        dresp_addr_ok = 1'b0;
  logic        dresp_data_ok = 1'b0;
  logic [31:0] dresp_rdata = 32'h0;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic        exc_refill;
  logic [31:0] badvaddr;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] m_rdata = 32'h0;

  dreq_issue #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_store(req_store), .req_size(req_size),
    .req_signed(req_signed), .req_vaddr(req_vaddr), .req_wdata(req_wdata),
    .flush(flush), .tr_paddr(tr_paddr), .tr_uncached(tr_uncached),
    .tr_refill(tr_refill), .tr_invalid(tr_invalid), .tr_modified(tr_modified),
    .dreq_valid(dreq_valid), .dreq_paddr(dreq_paddr), .dreq_store(dreq_store),
    .dreq_strobe(dreq_strobe), .dreq_size(dreq_size), .dreq_wdata(dreq_wdata),
    .dreq_uncached(dreq_uncached), .dresp_addr_ok(dresp_addr_ok),
    .dresp_data_ok(dresp_data_ok), .dresp_rdata(dresp_rdata),
    .stall(stall), .done(done), .rdata(rdata), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_refill(exc_refill), .badvaddr(badvaddr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_strobe(input int off, input int n);
    logic [3:0] s;
    s = 4'h0;
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + n) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input int n);
    logic [31:0] w;
    w = 32'h0;
    for (int j = 0; j < 4; j++) w[8*j +: 8] = wd[8*(j % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] raw, input int off, input int n,
                                         input logic sgn);
    logic [31:0] v;
    logic [31:0] keep;
    v = raw >> (8 * off);
    if (n < 4) begin
      keep = (32'h1 << (8 * n)) - 32'h1;
      v = v & keep;
      if (sgn && v[8*n-1]) v = v | ~keep;
    end
    return v;
  endfunction

  // Called at a negedge; returns at a negedge with the bus idle.
  task automatic do_txn(input logic st, input logic [1:0] sz, input logic sg,
                        input logic [31:0] va, input logic [31:0] pa, input logic [31:0] wd,
                        input logic rf, input logic iv, input logic md, input logic unc,
                        input int ad, input int dd, input int fk, input logic [31:0] raw);
    int         n;
    int         off;
    int         kd;
    logic [4:0] ec;
    logic       er;
    logic       killed;
    n      = nbytes(sz);
    off    = int'(va[1:0]);
    kd     = ad + dd;
    killed = 1'b0;
    ec     = 5'd0;
    er     = 1'b0;
    if ((off % n) != 0)   ec = st ? 5'd5 : 5'd4;
    else if (rf)          begin ec = st ? 5'd3 : 5'd2; er = 1'b1; end
    else if (iv)          ec = st ? 5'd3 : 5'd2;
    else if (md && st)    ec = 5'd1;

    req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg;
    req_vaddr = va; req_wdata = wd; tr_paddr = pa; tr_uncached = unc;
    tr_refill = rf; tr_invalid = iv; tr_modified = md;
    #1;
    check("stall_accept", 32'(stall), 32'(ec == 5'd0));

    if (ec != 5'd0) begin
      @(negedge clk);
      check("exc_valid", 32'(exc_valid), 32'h1);
      check("exc_code", 32'(exc_code), 32'(ec));
      check("exc_refill", 32'(exc_refill), 32'(er));
      check("badvaddr", badvaddr, va);
      check("dreq_valid_exc", 32'(dreq_valid), 32'h0);
      req_valid = 1'b0; tr_refill = 1'b0; tr_invalid = 1'b0; tr_modified = 1'b0;
      @(negedge clk);
      check("exc_pulse_end", 32'(exc_valid), 32'h0);
      check("dreq_valid_after_exc", 32'(dreq_valid), 32'h0);
    end else begin
      for (int k = 0; k <= kd; k++) begin
        @(negedge clk);
        check("stall_busy", 32'(stall), 32'h1);
        check("dreq_valid", 32'(dreq_valid), 32'(k <= ad));
        if (k <= ad) begin
          check("dreq_paddr", dreq_paddr, pa & 32'hFFFF_FFFC);
          check("dreq_strobe", 32'(dreq_strobe), 32'(m_strobe(off, n)));
          check("dreq_wdata", dreq_wdata, m_wdata(wd, n));
          check("dreq_store", 32'(dreq_store), 32'(st));
          check("dreq_size", 32'(dreq_size), 32'((sz == 2'd3) ? 2'd2 : sz));
          check("dreq_uncached", 32'(dreq_uncached), 32'(unc));
        end
        dresp_addr_ok = (k == ad);
        dresp_data_ok = (k == kd);
        dresp_rdata   = (k == kd) ? raw : $urandom;
        flush         = (k == fk);
        if (k == fk) killed = 1'b1;
      end
      @(negedge clk);
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; flush = 1'b0;
      if (!killed && !st) m_rdata = m_load(raw, int'(pa[1:0]), n, sg);
      check("done", 32'(done), 32'(!killed));
      check("rdata", rdata, m_rdata);
      check("stall_done", 32'(stall), 32'h0);
      check("dreq_valid_done", 32'(dreq_valid), 32'h0);
      req_valid = 1'b0;
      @(negedge clk);
      check("done_pulse_end", 32'(done), 32'h0);
      check("no_reaccept", 32'(dreq_valid), 32'h0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       st;
    logic       sg;
    logic       rf;
    logic       iv;
    logic       md;
    logic       unc;
    logic [1:0] sz;
    logic [31:0] va;
    logic [31:0] pa;
    int         ad;
    int         dd;
    int         fk;
    int         n;

    repeat (3) @(negedge clk);
    check("rst_dreq_valid", 32'(dreq_valid), 32'h0);
    check("rst_dreq_paddr", dreq_paddr, 32'h0);
    check("rst_dreq_strobe", 32'(dreq_strobe), 32'h0);
    check("rst_dreq_wdata", dreq_wdata, 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_exc_valid", 32'(exc_valid), 32'h0);
    check("rst_exc_code", 32'(exc_code), 32'h0);
    check("rst_badvaddr", badvaddr, 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    do_txn(1'b0, 2'd2, 1'b0, 32'h8000_1004, 32'h0000_1004, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0,
           2, 3, -1, 32'hDEAD_BEEF);
    check("plan_word_load", rdata, 32'hDEAD_BEEF);
    do_txn(1'b0, 2'd0, 1'b1, 32'h0000_2003, 32'h0000_5003, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0,
           1, 1, -1, 32'h80AA_BBCC);
    check("plan_sbyte", rdata, 32'hFFFF_FF80);
    do_txn(1'b0, 2'd0, 1'b0, 32'h0000_2003, 32'h0000_5003, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0,
           0, 2, -1, 32'h80AA_BBCC);
    check("plan_ubyte", rdata, 32'h0000_0080);
    do_txn(1'b1, 2'd1, 1'b0, 32'h1000_0006, 32'h0000_0006, 32'h0000_1234, 1'b0, 1'b0, 1'b0,
           1'b1, 0, 0, -1, 32'h0);
    check("plan_half_store_rdata", rdata, 32'h0000_0080);
    do_txn(1'b0, 2'd2, 1'b0, 32'h0040_0002, 32'h0000_0002, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0,
           0, 0, -1, 32'h0);
    do_txn(1'b1, 2'd2, 1'b0, 32'h0040_0010, 32'h0000_0010, 32'h5, 1'b1, 1'b0, 1'b0, 1'b0,
           0, 0, -1, 32'h0);
    do_txn(1'b1, 2'd2, 1'b0, 32'h0040_0020, 32'h0000_0020, 32'h5, 1'b0, 1'b0, 1'b1, 1'b0,
           0, 0, -1, 32'h0);
    do_txn(1'b0, 2'd2, 1'b0, 32'h0040_0030, 32'h0000_0030, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0,
           1, 0, -1, 32'h1122_3344);
    do_txn(1'b0, 2'd2, 1'b0, 32'h0040_0040, 32'h0000_0040, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0,
           2, 1, 1, 32'hCAFE_F00D);
    check("plan_flush_rdata", rdata, 32'h1122_3344);

    // Flush while idle blocks acceptance and exception reporting.
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_vaddr = 32'h0000_0101;
    tr_paddr = 32'h0000_0101; flush = 1'b1;
    #1;
    check("idle_flush_stall", 32'(stall), 32'h0);
    @(negedge clk);
    check("idle_flush_no_req", 32'(dreq_valid), 32'h0);
    check("idle_flush_no_exc", 32'(exc_valid), 32'h0);
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a transaction.
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_vaddr = 32'h0000_0200;
    tr_paddr = 32'h0000_0200;
    @(negedge clk);
    check("mid_rst_pre", 32'(dreq_valid), 32'h1);
    req_valid = 1'b0;
    resetn = 1'b0;
    #1;
    m_rdata = 32'h0;
    check("mid_rst_dreq_valid", 32'(dreq_valid), 32'h0);
    check("mid_rst_stall", 32'(stall), 32'h0);
    check("mid_rst_rdata", rdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'(dreq_valid), 32'h0);

    for (int t = 0; t < 250; t++) begin
      st  = 1'($urandom_range(0, 1));
      sg  = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      unc = 1'($urandom_range(0, 1));
      n   = nbytes(sz);
      va  = $urandom;
      if ($urandom_range(0, 3) != 0) va = va & ~(32'(n) - 32'h1);
      pa  = ($urandom & 32'hFFFF_FFFC) | (va & 32'h3);
      rf  = ($urandom_range(0, 9) == 0);
      iv  = ($urandom_range(0, 9) == 0);
      md  = ($urandom_range(0, 4) == 0);
      ad  = int'($urandom_range(0, 3));
      dd  = int'($urandom_range(0, 3));
      fk  = -1;
      if ($urandom_range(0, 3) == 0 && (ad + dd) > 0) fk = int'($urandom_range(0, ad + dd - 1));
      do_txn(st, sz, sg, va, pa, $urandom, rf, iv, md, unc, ad, dd, fk, $urandom);
      tr_refill = 1'b0; tr_invalid = 1'b0; tr_modified = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
